offset_search_ctrl: RTL and testbench

//  Sweeps the RX sampling offset 0..OS-1 and measures BER over a fixed bit window per offset.

---
 rtl/offset_search_ctrl_pkg.sv | 27 ++
 rtl/offset_search_timer.sv | 36 +++
 rtl/offset_search_ctrl.sv | 179 +++++++++++++++++
 tb/tb_offset_search_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/offset_search_ctrl_pkg.sv
// Shared definitions for the RX sampling-offset search controller:
// FSM state encoding, default parameter values and a counter-width helper.
package offset_search_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_APPLY,
    ST_HOLD
  } state_t;

  localparam int DEF_OS          = 4;
  localparam int DEF_NB_OFF      = 2;
  localparam int DEF_NB_CNT      = 64;
  localparam int DEF_MEAS_BITS   = 511;
  localparam int DEF_SETTLE_CYC  = 16;
  localparam int DEF_TIMEOUT_CYC = 65535;
  localparam int DEF_LOCK_THR    = 0;

  // Width of a down-counter that must hold LIMIT-1; at least one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/offset_search_timer.sv
// Loadable down-counter with a zero flag.
// load reloads LIMIT-1; count decrements until zero and then holds, so a
// state that exits on zero lasts exactly LIMIT cycles after a load on entry.
// Ports:
//   clock, reset  clock / synchronous active-high reset
//   load          reload the counter to LIMIT-1 (wins over count)
//   count         decrement enable
//   zero          counter is zero
module offset_search_timer
  import offset_search_ctrl_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic zero
);

  localparam int W = cnt_width(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= W'(LIMIT - 1);
    else if (count && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/offset_search_ctrl.sv
// RX sampling-offset search controller.
// Sweeps offsets 0..OS-1, measures the BER of a fixed bit window at each one,
// then applies and holds the offset with the fewest errors (lowest offset on
// ties). Windows that hit the watchdog are invalid and never selected; if all
// windows are invalid the sweep ends in IDLE with o_fail set.
// Ports:
//   clock, reset     clock / synchronous active-high reset
//   i_start          pulse: start or restart a sweep (ignored while busy)
//   i_error_count    BER block error count
//   i_bit_count      BER block bit count
//   o_offset         sampling offset to the datapath
//   o_rx_enable      RX/BER enable to the datapath
//   o_reset_ber      BER counter clear to the datapath
//   o_busy           sweep in progress
//   o_done           one-cycle pulse when the selected offset is in use
//   o_locked         selected offset held and its errors <= LOCK_THR
//   o_fail           last sweep found no valid window
//   o_best_offset    selected offset
//   o_best_errors    error count of the selected window
module offset_search_ctrl
  import offset_search_ctrl_pkg::*;
#(
  parameter int OS          = DEF_OS,
  parameter int NB_OFF      = DEF_NB_OFF,
  parameter int NB_CNT      = DEF_NB_CNT,
  parameter int MEAS_BITS   = DEF_MEAS_BITS,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int LOCK_THR    = DEF_LOCK_THR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_start,
  input  logic [NB_CNT-1:0] i_error_count,
  input  logic [NB_CNT-1:0] i_bit_count,
  output logic [NB_OFF-1:0] o_offset,
  output logic              o_rx_enable,
  output logic              o_reset_ber,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_locked,
  output logic              o_fail,
  output logic [NB_OFF-1:0] o_best_offset,
  output logic [NB_CNT-1:0] o_best_errors
);

  localparam logic [NB_OFF-1:0] OFF_LAST = NB_OFF'(OS - 1);
  localparam logic [NB_CNT-1:0] MEAS_LIM = NB_CNT'(MEAS_BITS);
  localparam logic [NB_CNT-1:0] LOCK_LIM = NB_CNT'(LOCK_THR);

  state_t state, next_state;

  logic              settle_zero, wdog_zero;
  logic              settle_load, wdog_load;
  logic              meas_done, sweep_start, apply_end, best_upd;
  logic              win_valid, any_valid;
  logic [NB_CNT-1:0] err_q, best_err, best_err_nxt;
  logic [NB_OFF-1:0] best_off, best_off_nxt;

  assign meas_done = (i_bit_count >= MEAS_LIM);

  // Settle timer serves both SETTLE and APPLY; the watchdog serves MEASURE.
  // Both reload on the edge that enters their state.
  assign settle_load = (next_state != state) &&
                       ((next_state == ST_SETTLE) || (next_state == ST_APPLY));
  assign wdog_load   = (next_state != state) && (next_state == ST_MEASURE);

  offset_search_timer #(.LIMIT(SETTLE_CYC)) u_settle (
    .clock (clock),
    .reset (reset),
    .load  (settle_load),
    .count ((state == ST_SETTLE) || (state == ST_APPLY)),
    .zero  (settle_zero)
  );

  offset_search_timer #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clock (clock),
    .reset (reset),
    .load  (wdog_load),
    .count (state == ST_MEASURE),
    .zero  (wdog_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    sweep_start = 1'b0;
    apply_end   = 1'b0;
    best_upd    = 1'b0;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (i_start) begin
          sweep_start = 1'b1;
          next_state  = ST_SETTLE;
        end
      end
      ST_SETTLE:  if (settle_zero) next_state = ST_MEASURE;
      ST_MEASURE: if (meas_done || wdog_zero) next_state = ST_EVAL;
      ST_EVAL: begin
        // Strict compare keeps the earlier (lower) offset on ties.
        best_upd   = win_valid && (err_q < best_err);
        next_state = (o_offset == OFF_LAST) ? ST_APPLY : ST_SETTLE;
      end
      ST_APPLY: begin
        if (settle_zero) begin
          apply_end  = 1'b1;
          next_state = any_valid ? ST_HOLD : ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Offset chosen for APPLY must include the update made by the last EVAL.
  assign best_err_nxt = best_upd ? err_q    : best_err;
  assign best_off_nxt = best_upd ? o_offset : best_off;

  // Outputs are registered from next_state so they switch on the same edge
  // as the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q       <= '0;
      win_valid   <= 1'b0;
      any_valid   <= 1'b0;
      best_err    <= '1;
      best_off    <= '0;
      o_offset    <= '0;
      o_rx_enable <= 1'b0;
      o_reset_ber <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_locked    <= 1'b0;
      o_fail      <= 1'b0;
    end else begin
      o_rx_enable <= next_state inside {ST_MEASURE, ST_HOLD};
      o_reset_ber <= next_state inside {ST_IDLE, ST_SETTLE, ST_APPLY};
      o_busy      <= next_state inside {ST_SETTLE, ST_MEASURE, ST_EVAL, ST_APPLY};
      o_done      <= apply_end && any_valid;

      if ((state == ST_MEASURE) && (next_state == ST_EVAL)) begin
        err_q     <= i_error_count;
        win_valid <= meas_done;
      end

      if (sweep_start) begin
        best_err  <= '1;
        best_off  <= '0;
        any_valid <= 1'b0;
        o_offset  <= '0;
        o_locked  <= 1'b0;
        o_fail    <= 1'b0;
      end

      if (state == ST_EVAL) begin
        best_err <= best_err_nxt;
        best_off <= best_off_nxt;
        if (win_valid) any_valid <= 1'b1;
        o_offset <= (next_state == ST_APPLY) ? best_off_nxt : o_offset + 1'b1;
      end

      if (apply_end) begin
        if (any_valid) begin
          o_locked <= (best_err <= LOCK_LIM);
        end else begin
          o_fail   <= 1'b1;
          o_offset <= '0;
        end
      end
    end
  end

  assign o_best_offset = best_off;
  assign o_best_errors = best_err;

endmodule

// File: tb/tb_offset_search_ctrl.sv
// Bench for offset_search_ctrl with a behavioural BER stub: bit_count rises
// every 4 rx_enable cycles, error_count reports a per-offset value, both
// cleared by reset_ber; a per-offset freeze mask stops bit_count.
module tb_offset_search_ctrl;

  localparam int OS = 4, NB_OFF = 2, NB_CNT = 64;
  localparam int MEAS_BITS = 31, SETTLE_CYC = 16, TIMEOUT_CYC = 300, LOCK_THR = 0;
  localparam int BOUND = 4000;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              i_start = 1'b0;
  logic [NB_CNT-1:0] i_error_count, i_bit_count;
  logic [NB_OFF-1:0] o_offset, o_best_offset;
  logic              o_rx_enable, o_reset_ber, o_busy, o_done, o_locked, o_fail;
  logic [NB_CNT-1:0] o_best_errors;

  int n_chk = 0, n_pass = 0;

  always #5 clock = ~clock;

  offset_search_ctrl #(
    .OS(OS), .NB_OFF(NB_OFF), .NB_CNT(NB_CNT), .MEAS_BITS(MEAS_BITS),
    .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .LOCK_THR(LOCK_THR)
  ) dut (
    .clock(clock), .reset(reset), .i_start(i_start),
    .i_error_count(i_error_count), .i_bit_count(i_bit_count),
    .o_offset(o_offset), .o_rx_enable(o_rx_enable), .o_reset_ber(o_reset_ber),
    .o_busy(o_busy), .o_done(o_done), .o_locked(o_locked), .o_fail(o_fail),
    .o_best_offset(o_best_offset), .o_best_errors(o_best_errors)
  );

  // BER stub
  int unsigned err_tab [OS];
  logic [OS-1:0] frozen;
  logic [1:0]    div;
  always @(posedge clock) begin
    if (o_reset_ber) begin
      i_bit_count   <= '0;
      i_error_count <= '0;
      div           <= '0;
    end else begin
      i_error_count <= NB_CNT'(err_tab[o_offset]);
      if (o_rx_enable) begin
        div <= div + 2'd1;
        if (div == 2'd3 && !frozen[o_offset]) i_bit_count <= i_bit_count + 64'd1;
      end
    end
  end

  // Monitor: offsets of measurement windows, their lengths, reset_ber run
  // lengths that begin mid-sweep, done pulses, rx/reset_ber overlap.
  logic mon_clr = 1'b0;
  logic prev_rx = 1'b0, prev_rb = 1'b1, rx_busy = 1'b0, rb_busy = 1'b0;
  int   rx_len = 0, rb_len = 0, done_cnt = 0, overlap_cnt = 0;
  int   win_off_q[$], win_len_q[$], rb_len_q[$];
  always @(negedge clock) begin
    prev_rx <= o_rx_enable;
    prev_rb <= o_reset_ber;
    if (mon_clr) begin
      win_off_q.delete(); win_len_q.delete(); rb_len_q.delete();
      done_cnt <= 0; overlap_cnt <= 0; rx_busy <= 1'b0; rb_busy <= 1'b0;
      rx_len <= 0; rb_len <= 0;
    end else begin
      if (o_done) done_cnt <= done_cnt + 1;
      if (o_rx_enable && o_reset_ber) overlap_cnt <= overlap_cnt + 1;
      if (o_rx_enable) begin
        if (!prev_rx) begin
          rx_busy <= o_busy; rx_len <= 1;
          if (o_busy) win_off_q.push_back(int'(o_offset));
        end else rx_len <= rx_len + 1;
      end else if (prev_rx && rx_busy) win_len_q.push_back(rx_len);
      if (o_reset_ber) begin
        if (!prev_rb) begin rb_busy <= o_busy; rb_len <= 1; end
        else rb_len <= rb_len + 1;
      end else if (prev_rb && rb_busy) rb_len_q.push_back(rb_len);
    end
  end

  task automatic clear_mon();
    mon_clr = 1'b1; repeat (2) @(negedge clock); mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1; @(negedge clock); i_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; repeat (3) @(negedge clock);
    n_chk++; if (o_offset !== 2'd0) $display("FAIL rst_offset got %0d exp 0", o_offset); else n_pass++;
    n_chk++; if (o_rx_enable !== 1'b0) $display("FAIL rst_rx_enable got %b exp 0", o_rx_enable); else n_pass++;
    n_chk++; if (o_reset_ber !== 1'b1) $display("FAIL rst_reset_ber got %b exp 1", o_reset_ber); else n_pass++;
    n_chk++; if ({o_busy, o_done, o_locked, o_fail} !== 4'b0) $display("FAIL rst_flags got %b exp 0000", {o_busy, o_done, o_locked, o_fail}); else n_pass++;
    n_chk++; if (o_best_offset !== 2'd0) $display("FAIL rst_best_off got %0d exp 0", o_best_offset); else n_pass++;
    n_chk++; if (o_best_errors !== '1) $display("FAIL rst_best_err got %h exp all-ones", o_best_errors); else n_pass++;
    reset = 1'b0; repeat (2) @(negedge clock);
    n_chk++; if ({o_busy, o_reset_ber} !== 2'b01) $display("FAIL idle_hold got busy/rb %b exp 01", {o_busy, o_reset_ber}); else n_pass++;
  endtask

  // Full sweep against the model: best = lowest offset among non-frozen
  // windows with the minimum error count; no valid window means fail.
  task automatic test_sweep(input string nm, input int unsigned e0, e1, e2, e3, input logic [3:0] fz);
    int unsigned min_e;
    int exp_off, cyc, exp_runs;
    bit exp_fail, have;
    logic [NB_CNT-1:0] exp_err;
    err_tab[0] = e0; err_tab[1] = e1; err_tab[2] = e2; err_tab[3] = e3; frozen = fz;
    have = 0; min_e = 0; exp_off = 0;
    for (int i = 0; i < OS; i++)
      if (!fz[i] && (!have || err_tab[i] < min_e)) begin have = 1; min_e = err_tab[i]; end
    for (int i = OS - 1; i >= 0; i--)
      if (!fz[i] && err_tab[i] == min_e) exp_off = i;
    exp_fail = !have;
    exp_err  = exp_fail ? '1 : NB_CNT'(min_e);
    if (exp_fail) exp_off = 0;
    clear_mon();
    exp_runs = (exp_fail ? 3 : 4) + (o_rx_enable ? 1 : 0);  // restart from HOLD adds a run
    pulse_start();
    cyc = 0;
    while (o_busy && cyc < BOUND) begin @(negedge clock); cyc++; end
    repeat (2) @(negedge clock);
    n_chk++; if (cyc >= BOUND) $display("FAIL %s_timeout busy for %0d cycles, limit %0d", nm, cyc, BOUND); else n_pass++;
    n_chk++; if (win_off_q.size() != OS) $display("FAIL %s_nwin got %0d exp %0d", nm, win_off_q.size(), OS); else n_pass++;
    for (int i = 0; i < win_off_q.size() && i < OS; i++) begin
      n_chk++; if (win_off_q[i] != i) $display("FAIL %s_win_order[%0d] got %0d exp %0d", nm, i, win_off_q[i], i); else n_pass++;
    end
    for (int i = 0; i < win_len_q.size() && i < OS; i++) begin
      n_chk++;
      if (fz[i] ? (win_len_q[i] != TIMEOUT_CYC) : (win_len_q[i] >= TIMEOUT_CYC))
        $display("FAIL %s_win_len[%0d] got %0d exp %s %0d", nm, i, win_len_q[i], fz[i] ? "==" : "<", TIMEOUT_CYC);
      else n_pass++;
    end
    n_chk++; if (rb_len_q.size() != exp_runs) $display("FAIL %s_nsettle got %0d exp %0d", nm, rb_len_q.size(), exp_runs); else n_pass++;
    foreach (rb_len_q[i]) begin
      n_chk++; if (rb_len_q[i] != SETTLE_CYC) $display("FAIL %s_settle_len[%0d] got %0d exp %0d", nm, i, rb_len_q[i], SETTLE_CYC); else n_pass++;
    end
    n_chk++; if (overlap_cnt != 0) $display("FAIL %s_rx_during_reset got %0d cycles exp 0", nm, overlap_cnt); else n_pass++;
    n_chk++; if (done_cnt != (exp_fail ? 0 : 1)) $display("FAIL %s_done_pulses got %0d exp %0d", nm, done_cnt, exp_fail ? 0 : 1); else n_pass++;
    n_chk++; if (o_fail !== exp_fail) $display("FAIL %s_fail got %b exp %b", nm, o_fail, exp_fail); else n_pass++;
    n_chk++; if (int'(o_best_offset) != exp_off) $display("FAIL %s_best_off got %0d exp %0d", nm, o_best_offset, exp_off); else n_pass++;
    n_chk++; if (o_best_errors !== exp_err) $display("FAIL %s_best_err got %0d exp %0d", nm, o_best_errors, exp_err); else n_pass++;
    n_chk++; if (int'(o_offset) != exp_off) $display("FAIL %s_offset got %0d exp %0d", nm, o_offset, exp_off); else n_pass++;
    n_chk++; if (o_locked !== (!exp_fail && exp_err <= NB_CNT'(LOCK_THR))) $display("FAIL %s_locked got %b exp %b", nm, o_locked, !exp_fail && exp_err <= NB_CNT'(LOCK_THR)); else n_pass++;
    n_chk++; if ({o_rx_enable, o_reset_ber, o_busy} !== {!exp_fail, exp_fail, 1'b0}) $display("FAIL %s_final_ctl got rx/rb/busy %b exp %b", nm, {o_rx_enable, o_reset_ber, o_busy}, {!exp_fail, exp_fail, 1'b0}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    err_tab[0] = 40; err_tab[1] = 3; err_tab[2] = 0; err_tab[3] = 17; frozen = '0;
    pulse_start();
    cyc = 0;
    while (!(o_busy && o_rx_enable && o_offset == 2'd2) && cyc < BOUND) begin @(negedge clock); cyc++; end
    n_chk++; if (cyc >= BOUND) $display("FAIL midrst_reach got %0d cycles, limit %0d", cyc, BOUND); else n_pass++;
    reset = 1'b1; @(negedge clock);
    n_chk++; if ({o_offset, o_rx_enable, o_reset_ber, o_busy} !== 5'b00010) $display("FAIL midrst_ctl got off/rx/rb/busy %b exp 00010", {o_offset, o_rx_enable, o_reset_ber, o_busy}); else n_pass++;
    n_chk++; if (o_best_errors !== '1) $display("FAIL midrst_best_err got %h exp all-ones", o_best_errors); else n_pass++;
    n_chk++; if ({o_locked, o_fail} !== 2'b00) $display("FAIL midrst_flags got %b exp 00", {o_locked, o_fail}); else n_pass++;
    reset = 1'b0; @(negedge clock);
    test_sweep("after_rst", 40, 3, 0, 17, 4'b0000);
  endtask

  task automatic test_start_ignored();
    int cyc;
    err_tab[0] = 40; err_tab[1] = 3; err_tab[2] = 0; err_tab[3] = 17; frozen = '0;
    clear_mon();
    pulse_start();
    repeat (3) @(negedge clock);
    pulse_start();  // lands in SETTLE
    cyc = 0;
    while (!(o_busy && !o_rx_enable && !o_reset_ber) && cyc < BOUND) begin @(negedge clock); cyc++; end
    n_chk++; if (cyc >= BOUND) $display("FAIL ign_reach_eval got %0d cycles, limit %0d", cyc, BOUND); else n_pass++;
    pulse_start();  // lands in EVAL
    cyc = 0;
    while (o_busy && cyc < BOUND) begin @(negedge clock); cyc++; end
    repeat (2) @(negedge clock);
    n_chk++; if (cyc >= BOUND) $display("FAIL ign_timeout got %0d cycles, limit %0d", cyc, BOUND); else n_pass++;
    n_chk++; if (win_off_q.size() != OS) $display("FAIL ign_nwin got %0d exp %0d", win_off_q.size(), OS); else n_pass++;
    for (int i = 0; i < win_off_q.size() && i < OS; i++) begin
      n_chk++; if (win_off_q[i] != i) $display("FAIL ign_win_order[%0d] got %0d exp %0d", i, win_off_q[i], i); else n_pass++;
    end
    n_chk++; if (done_cnt != 1) $display("FAIL ign_done got %0d exp 1", done_cnt); else n_pass++;
    n_chk++; if ({o_best_offset, o_locked} !== 3'b101) $display("FAIL ign_result got best/locked %b exp 101", {o_best_offset, o_locked}); else n_pass++;
    pulse_start();  // in HOLD: restarts
    n_chk++; if ({o_locked, o_offset, o_busy, o_rx_enable} !== 5'b00010) $display("FAIL hold_restart got lock/off/busy/rx %b exp 00010", {o_locked, o_offset, o_busy, o_rx_enable}); else n_pass++;
    cyc = 0;
    while (o_busy && cyc < BOUND) begin @(negedge clock); cyc++; end
    repeat (2) @(negedge clock);
    n_chk++; if ({o_best_offset, o_locked, o_offset} !== 5'b10110) $display("FAIL restart_result got best/lock/off %b exp 10110", {o_best_offset, o_locked, o_offset}); else n_pass++;
  endtask

  task automatic test_random();
    int unsigned e [4];
    logic [3:0] fz;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) e[i] = $urandom_range(0, 6);
      fz = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      test_sweep($sformatf("rand%0d", k), e[0], e[1], e[2], e[3], fz);
    end
  endtask

  initial begin
    for (int i = 0; i < OS; i++) err_tab[i] = 0;
    frozen = '0;
    test_reset();
    test_sweep("basic", 40, 3, 0, 17, 4'b0000);
    test_sweep("tie", 5, 5, 9, 5, 4'b0000);
    test_sweep("one_frozen", 3, 1, 2, 5, 4'b0010);
    test_sweep("all_frozen", 1, 2, 3, 4, 4'b1111);
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
